// File: rtl/rk_history_buffer_pkg.sv
// Shared definitions for the residual history buffer.
// Holds default parameter values, the write-side FSM state type and the
// derived widths used by the interface, the top and the testbench.
package rk_history_buffer_pkg;

  localparam int DEF_NO_OF_UNITS   = 8;
  localparam int DEF_ELEMENT_WIDTH = 32;
  localparam int DEF_WORDS_PER_GEN = 95;
  localparam int DEF_NUM_GEN       = 4;
  localparam int DEF_ADDR_W        = 20;

  // clog2 that never returns 0, so single-entry ranges still get a 1-bit field
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_AGE_W = width_of(DEF_NUM_GEN);
  localparam int DEF_CNT_W = DEF_AGE_W + 1;
  localparam int DEF_PTR_W = width_of(DEF_WORDS_PER_GEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/rk_history_buffer_if.sv
// Write/read bus of the residual history buffer.
//   master : producer/consumer side (drives wr_* requests and rd_* requests)
//   slave  : buffer side (returns wr_ready, read response, gen_count, overflow)
interface rk_history_buffer_if
  import rk_history_buffer_pkg::*;
#(
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int NUM_GEN       = DEF_NUM_GEN,
  parameter int ADDR_W        = DEF_ADDR_W
);
  localparam int DATA_W = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam int AGE_W  = width_of(NUM_GEN);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              rd_req;
  logic [AGE_W-1:0]  rd_age;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic [AGE_W:0]    gen_count;
  logic              overflow;

  modport master (
    output wr_valid, wr_data, wr_last, rd_req, rd_age, rd_addr,
    input  wr_ready, rd_valid, rd_data, rd_err, gen_count, overflow
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_req, rd_age, rd_addr,
    output wr_ready, rd_valid, rd_data, rd_err, gen_count, overflow
  );

endinterface

// File: rtl/rk_history_buffer_bank_ram.sv
// rk_bank_ram: simple dual-port storage for all generations.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port, rdata registered (1-cycle latency)
// Contents are not reset.
module rk_bank_ram #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 380,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rk_history_buffer.sv
// Ring of NUM_GEN residual vectors. One vector is filled beat by beat, then
// committed; committed vectors are read back by age (0 = newest).
//   clk   : clock
//   reset : synchronous, active-low
//   flush : discard all generations and abort any fill
//   bus   : write stream, read request/response, gen_count, overflow
//
// state  | meaning
// IDLE   | no vector open; next accepted beat is word 0 of slot wr_gen
// FILL   | vector open; beats land at wr_ptr
// COMMIT | one cycle: publish the filled slot, advance wr_gen
module rk_history_buffer
  import rk_history_buffer_pkg::*;
#(
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int WORDS_PER_GEN = DEF_WORDS_PER_GEN,
  parameter int NUM_GEN       = DEF_NUM_GEN,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  rk_history_buffer_if.slave  bus
);

  localparam int DATA_W    = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam int AGE_W     = width_of(NUM_GEN);
  localparam int CNT_W     = AGE_W + 1;
  localparam int PTR_W     = width_of(WORDS_PER_GEN + 1);
  localparam int RAM_DEPTH = NUM_GEN * WORDS_PER_GEN;
  localparam int RAM_AW    = width_of(RAM_DEPTH);

  state_t            state;
  logic [AGE_W-1:0]  wr_gen;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  gen_count;
  logic [PTR_W-1:0]  len_q [NUM_GEN];
  logic              rd_valid_q;
  logic              rd_err_q;
  logic              overflow_q;

  logic              wr_ready_int;
  logic              wr_fire;
  logic              wr_end;
  logic [AGE_W-1:0]  rd_slot;
  logic              rd_hit;
  logic              rd_ok;
  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_q;

  assign wr_ready_int = reset && (state != ST_COMMIT);
  assign wr_fire      = bus.wr_valid && wr_ready_int;
  assign wr_end       = bus.wr_last || (wr_ptr == PTR_W'(WORDS_PER_GEN - 1));

  // Ages count back from the last committed slot; the slot at wr_gen is the
  // one being filled and is never inside the gen_count window.
  assign rd_slot = wr_gen - AGE_W'(1) - bus.rd_age;
  assign rd_hit  = ({1'b0, bus.rd_age} < gen_count) &&
                   (bus.rd_addr < ADDR_W'(len_q[rd_slot]));
  assign rd_ok   = rd_hit && !flush;

  assign ram_we    = wr_fire && !flush;
  assign ram_waddr = RAM_AW'(wr_gen) * RAM_AW'(WORDS_PER_GEN) + RAM_AW'(wr_ptr);
  assign ram_re    = bus.rd_req && rd_ok;
  assign ram_raddr = rd_hit ? RAM_AW'(rd_slot) * RAM_AW'(WORDS_PER_GEN) + RAM_AW'(bus.rd_addr)
                            : '0;

  rk_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wr_gen     <= '0;
      wr_ptr     <= '0;
      gen_count  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_GEN; i++) len_q[i] <= '0;
    end else begin
      overflow_q <= 1'b0;
      rd_valid_q <= bus.rd_req;
      rd_err_q   <= bus.rd_req && !rd_ok;
      if (flush) begin
        state     <= ST_IDLE;
        wr_ptr    <= '0;
        gen_count <= '0;
      end else begin
        unique case (state)
          ST_IDLE, ST_FILL: begin
            if (wr_fire) begin
              // Starting a vector on a full ring reclaims the oldest slot.
              if (state == ST_IDLE && gen_count == CNT_W'(NUM_GEN)) begin
                gen_count  <= gen_count - CNT_W'(1);
                overflow_q <= 1'b1;
              end
              if (wr_end) begin
                state         <= ST_COMMIT;
                len_q[wr_gen] <= wr_ptr + PTR_W'(1);
              end else begin
                state  <= ST_FILL;
                wr_ptr <= wr_ptr + PTR_W'(1);
              end
            end
          end
          ST_COMMIT: begin
            wr_gen    <= wr_gen + AGE_W'(1);
            gen_count <= gen_count + CNT_W'(1);
            wr_ptr    <= '0;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_ready  = wr_ready_int;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.rd_data   = (rd_valid_q && !rd_err_q) ? ram_q : '0;
  assign bus.gen_count = gen_count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_rk_history_buffer.sv
module tb_rk_history_buffer;
  import rk_history_buffer_pkg::*;

  localparam int NG  = DEF_NUM_GEN;
  localparam int WPG = DEF_WORDS_PER_GEN;
  localparam int DW  = DEF_NO_OF_UNITS * DEF_ELEMENT_WIDTH;
  localparam int AGW = DEF_AGE_W;
  localparam int CW  = DEF_CNT_W;
  localparam int ADW = DEF_ADDR_W;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  rk_history_buffer_if bus ();

  rk_history_buffer dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: committed vectors as a queue (front = oldest), each identified by
  // the seed its words were generated from.
  typedef struct {
    int unsigned seed;
    int          len;
  } vec_t;

  vec_t        hist[$];
  int unsigned cur_seed;
  int          cur_len;
  bit          commit_pending;

  bit          last_accept;
  bit          exp_ready, obs_ready, exp_ovf, exp_rd_err;
  logic [DW-1:0] exp_rd_data;
  int          ovf_seen;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [DW-1:0] word_of(input int unsigned seed, input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DEF_NO_OF_UNITS; i++)
      w[i*DEF_ELEMENT_WIDTH +: DEF_ELEMENT_WIDTH] =
        DEF_ELEMENT_WIDTH'(seed ^ (idx * 32'h9E3779B1) ^ (i * 32'h85EBCA6B) ^ 32'h1);
    return w;
  endfunction

  task automatic model_clear();
    hist.delete();
    cur_len = 0;
    commit_pending = 0;
  endtask

  // One clock of stimulus; leaves exp_* describing what the DUT should show
  // #1 after the edge.
  task automatic step(input bit wv, input bit wl, input bit rq, input int age,
                      input int addr, input bit fl);
    @(negedge clk);
    obs_ready = bus.wr_ready;
    exp_ready = !commit_pending;
    if (cur_len == 0 && !commit_pending) cur_seed = $urandom;
    bus.wr_valid = wv;
    bus.wr_last  = wl;
    bus.wr_data  = word_of(cur_seed, cur_len);
    bus.rd_req   = rq;
    bus.rd_age   = AGW'(age);
    bus.rd_addr  = ADW'(addr);
    flush        = fl;
    last_accept  = wv && !commit_pending && !fl;
    exp_rd_data  = '0;
    if (!rq) exp_rd_err = 1'b0;
    else if (fl || age >= hist.size() || addr >= hist[hist.size()-1-age].len) exp_rd_err = 1'b1;
    else begin
      exp_rd_err  = 1'b0;
      exp_rd_data = word_of(hist[hist.size()-1-age].seed, addr);
    end
    @(posedge clk);
    exp_ovf = 1'b0;
    if (fl) model_clear();
    else if (commit_pending) begin
      hist.push_back('{seed: cur_seed, len: cur_len});
      cur_len = 0;
      commit_pending = 0;
    end else if (last_accept) begin
      if (cur_len == 0 && hist.size() == NG) begin
        void'(hist.pop_front());
        exp_ovf = 1'b1;
      end
      cur_len++;
      if (wl || cur_len == WPG) commit_pending = 1;
    end
    #1;
    if (bus.overflow === 1'b1) ovf_seen++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic rd(input int age, input int addr);
    step(1'b0, 1'b0, 1'b1, age, addr, 1'b0);
  endtask

  task automatic write_vec(input int n, input bit use_last, output int unsigned seed);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < n + 8) begin
      step(1'b1, use_last && (sent == n - 1), 1'b0, 0, 0, 1'b0);
      if (last_accept) sent++;
      guard++;
    end
    seed = cur_seed;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL write_vec_accept got=%0d want=%0d", sent, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_req   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_age   = '0;
    bus.rd_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_wr_ready got=%b want=0", bus.wr_ready);
    end
    checks++;
    if ({bus.rd_valid, bus.rd_err, bus.overflow} !== 3'b000 || bus.rd_data !== '0 || bus.gen_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v/e/o=%b%b%b cnt=%0d data=%h want 000 cnt=0 data=0",
               bus.rd_valid, bus.rd_err, bus.overflow, bus.gen_count, bus.rd_data);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b want=1", bus.wr_ready);
    end
    model_clear();
  endtask

  task automatic test_full_length();
    int unsigned s;
    apply_reset();
    write_vec(WPG, 1'b0, s);
    idle();
    checks++;
    if (obs_ready !== 1'b0 || bus.gen_count !== CW'(1)) begin
      errors++; $display("FAIL full_commit got ready=%b cnt=%0d want ready=0 cnt=1", obs_ready, bus.gen_count);
    end
    rd(0, WPG - 1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.rd_data !== word_of(s, WPG - 1)) begin
      errors++;
      $display("FAIL full_read_last got v=%b e=%b d=%h want v=1 e=0 d=%h",
               bus.rd_valid, bus.rd_err, bus.rd_data, word_of(s, WPG - 1));
    end
    idle();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL full_valid_one_cycle got=%b want=0", bus.rd_valid);
    end
  endtask

  task automatic test_short_vector();
    int unsigned s;
    apply_reset();
    write_vec(10, 1'b1, s);
    idle();
    rd(0, 9);
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_data !== word_of(s, 9)) begin
      errors++; $display("FAIL short_addr9 got e=%b d=%h want e=0 d=%h", bus.rd_err, bus.rd_data, word_of(s, 9));
    end
    rd(0, 10);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.rd_data !== '0) begin
      errors++; $display("FAIL short_addr10 got v=%b e=%b d=%h want v=1 e=1 d=0", bus.rd_valid, bus.rd_err, bus.rd_data);
    end
  endtask

  task automatic test_overflow();
    int unsigned seeds[5];
    apply_reset();
    ovf_seen = 0;
    for (int k = 0; k < 4; k++) write_vec(3 + k, 1'b1, seeds[k]);
    idle();
    checks++;
    if (bus.gen_count !== CW'(4) || ovf_seen != 0) begin
      errors++; $display("FAIL ovf_full got cnt=%0d pulses=%0d want cnt=4 pulses=0", bus.gen_count, ovf_seen);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.gen_count !== CW'(3)) begin
      errors++; $display("FAIL ovf_start got ovf=%b cnt=%0d want ovf=1 cnt=3", bus.overflow, bus.gen_count);
    end
    write_vec(1, 1'b1, seeds[4]);
    idle();
    checks++;
    if (bus.gen_count !== CW'(4) || ovf_seen != 1) begin
      errors++; $display("FAIL ovf_after got cnt=%0d pulses=%0d want cnt=4 pulses=1", bus.gen_count, ovf_seen);
    end
    rd(3, 1);
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_data !== word_of(seeds[1], 1)) begin
      errors++; $display("FAIL ovf_age3 got e=%b d=%h want e=0 d=%h", bus.rd_err, bus.rd_data, word_of(seeds[1], 1));
    end
    rd(0, 1);
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_data !== word_of(seeds[4], 1)) begin
      errors++; $display("FAIL ovf_age0 got e=%b d=%h want e=0 d=%h", bus.rd_err, bus.rd_data, word_of(seeds[4], 1));
    end
    rd(3, 4);
    checks++;
    if (bus.rd_err !== 1'b1) begin
      errors++; $display("FAIL ovf_age3_len got e=%b want e=1", bus.rd_err);
    end
  endtask

  task automatic test_flush();
    int unsigned s;
    apply_reset();
    for (int k = 0; k < 3; k++) write_vec(5, 1'b1, s);
    write_vec(2, 1'b0, s);
    step(1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.gen_count !== '0) begin
      errors++; $display("FAIL flush_cycle got v=%b e=%b cnt=%0d want v=1 e=1 cnt=0", bus.rd_valid, bus.rd_err, bus.gen_count);
    end
    for (int a = 0; a < NG; a++) begin
      rd(a, 0);
      checks++;
      if (bus.rd_err !== 1'b1 || bus.rd_data !== '0) begin
        errors++; $display("FAIL flush_age%0d got e=%b d=%h want e=1 d=0", a, bus.rd_err, bus.rd_data);
      end
    end
    write_vec(3, 1'b1, s);
    idle();
    rd(0, 0);
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_data !== word_of(s, 0)) begin
      errors++; $display("FAIL flush_refill_w0 got e=%b d=%h want e=0 d=%h", bus.rd_err, bus.rd_data, word_of(s, 0));
    end
    rd(0, 3);
    checks++;
    if (bus.rd_err !== 1'b1) begin
      errors++; $display("FAIL flush_refill_len got e=%b want e=1", bus.rd_err);
    end
  endtask

  task automatic test_read_during_commit();
    int unsigned s1, s2;
    apply_reset();
    write_vec(4, 1'b1, s1);
    idle();
    write_vec(4, 1'b1, s2);
    rd(0, 1);
    checks++;
    if (obs_ready !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== word_of(s1, 1)) begin
      errors++;
      $display("FAIL commit_read got rdy=%b e=%b d=%h want rdy=0 e=0 d=%h", obs_ready, bus.rd_err, bus.rd_data, word_of(s1, 1));
    end
    rd(0, 1);
    checks++;
    if (bus.gen_count !== CW'(2) || bus.rd_data !== word_of(s2, 1)) begin
      errors++; $display("FAIL post_commit_read got cnt=%0d d=%h want cnt=2 d=%h", bus.gen_count, bus.rd_data, word_of(s2, 1));
    end
  endtask

  task automatic test_reset_mid_fill();
    int unsigned s;
    apply_reset();
    write_vec(3, 1'b1, s);
    idle();
    write_vec(5, 1'b0, s);
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.wr_valid = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_age = '0;
    bus.rd_addr = '0;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready_low got=%b want=0", bus.wr_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rd_valid, bus.rd_err, bus.overflow} !== 3'b000 || bus.rd_data !== '0 || bus.gen_count !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got v/e/o=%b%b%b cnt=%0d want 000 cnt=0", bus.rd_valid, bus.rd_err, bus.overflow, bus.gen_count);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_req = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready_after got=%b want=1", bus.wr_ready);
    end
    write_vec(2, 1'b1, s);
    idle();
    rd(0, 1);
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_data !== word_of(s, 1) || bus.gen_count !== CW'(1)) begin
      errors++; $display("FAIL midreset_refill got e=%b cnt=%0d d=%h want e=0 cnt=1 d=%h", bus.rd_err, bus.gen_count, bus.rd_data, word_of(s, 1));
    end
  endtask

  task automatic test_random();
    bit wv, wl, rq, fl;
    int age, addr;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      wv   = ($urandom_range(0, 9) < 7);
      wl   = ($urandom_range(0, 15) == 0);
      rq   = $urandom_range(0, 1);
      fl   = ($urandom_range(0, 99) == 0);
      age  = $urandom_range(0, NG - 1);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WPG + 3) : $urandom_range(0, 12);
      step(wv, wl, rq, age, addr, fl);
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, obs_ready, exp_ready);
      end
      checks++;
      if (bus.rd_valid !== rq || (rq && (bus.rd_err !== exp_rd_err || bus.rd_data !== exp_rd_data))) begin
        errors++;
        $display("FAIL rnd_read n=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 n, bus.rd_valid, bus.rd_err, bus.rd_data, rq, exp_rd_err, exp_rd_data);
      end
      checks++;
      if (bus.gen_count !== CW'(hist.size()) || bus.overflow !== exp_ovf) begin
        errors++;
        $display("FAIL rnd_count n=%0d got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                 n, bus.gen_count, bus.overflow, hist.size(), exp_ovf);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ovf_seen = 0;
    test_reset();
    test_full_length();
    test_short_vector();
    test_overflow();
    test_flush();
    test_read_during_commit();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rk_history_buffer.md
RK_HISTORY_BUFFER -- requirements
Module: rk_history_buffer

Interface
REQ-001 SHALL have parameter NO_OF_UNITS, default 8, lanes per word.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 32, bits per lane element.
REQ-003 SHALL have parameter WORDS_PER_GEN, default 95, maximum words per stored vector (760 equations / 8 lanes).
REQ-004 SHALL have parameter NUM_GEN, default 4, number of stored residual generations (power of two, >=2).
REQ-005 SHALL have parameter ADDR_W, default 20, read address width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port flush  in  1  synchronous discard of all generations.
REQ-009 SHALL have port wr_valid  in  1  write beat offered.
REQ-010 SHALL have port wr_ready  out  1  write beat accepted when high with wr_valid.
REQ-011 SHALL have port wr_data  in  NO_OF_UNITS*ELEMENT_WIDTH  one vector word.
REQ-012 SHALL have port wr_last  in  1  final word of current vector.
REQ-013 SHALL have port rd_req  in  1  read request.
REQ-014 SHALL have port rd_age  in  clog2(NUM_GEN)  0 = newest committed vector (r_k-1), 1 = older, ...
REQ-015 SHALL have port rd_addr  in  ADDR_W  word index within vector.
REQ-016 SHALL have ports rd_valid  out  1,  rd_data  out  NO_OF_UNITS*ELEMENT_WIDTH,  and rd_err  out  1  (read response).
REQ-017 SHALL have ports gen_count  out  clog2(NUM_GEN)+1  (committed readable generations) and overflow  out  1  (one-cycle pulse).

Function
REQ-018 SHALL implement FSM states IDLE, FILL, COMMIT; reset and flush enter IDLE.
REQ-019 wr_ready SHALL be 1 in IDLE and FILL, 0 in COMMIT and while reset is low.
REQ-020 An accepted beat in IDLE SHALL move to FILL, write word 0 of slot wr_gen, and set wr_ptr to 1.
REQ-021 Each accepted beat in FILL SHALL write mem[wr_gen][wr_ptr] and increment wr_ptr.
REQ-022 An accepted beat with wr_last=1, or with wr_ptr = WORDS_PER_GEN-1, SHALL move to COMMIT, recording len[wr_gen] = wr_ptr+1; wr_last is ignored otherwise.
REQ-023 COMMIT SHALL last exactly one cycle: wr_gen <- (wr_gen+1) mod NUM_GEN, gen_count <- gen_count+1, wr_ptr <- 0, then IDLE.
REQ-024 On the IDLE->FILL transition with gen_count = NUM_GEN, gen_count SHALL decrement by 1 in that cycle and overflow SHALL pulse for one cycle (oldest slot being overwritten).
REQ-025 rd_req sampled at edge t SHALL yield rd_valid=1 at t+1 for exactly one cycle; rd_valid SHALL be 0 otherwise.
REQ-026 Read slot SHALL be (wr_gen-1-rd_age) mod NUM_GEN, using the state registered before edge t.
REQ-027 If rd_age < gen_count and rd_addr < len[slot]: rd_data = stored word, rd_err=0; otherwise rd_data=0, rd_err=1.
REQ-028 The slot being filled SHALL never be readable; reads in COMMIT use pre-commit pointers.
REQ-029 flush SHALL clear gen_count, wr_ptr, wr_gen-relative contents validity and abort any fill; a beat offered with flush is dropped; rd_req in the flush cycle SHALL return rd_err=1.
REQ-030 Simultaneous write and read SHALL both proceed in the same cycle with no stall.

Reset
REQ-031 With reset low at an edge: state=IDLE, wr_gen=0, wr_ptr=0, gen_count=0, rd_valid=0, rd_data=0, rd_err=0, overflow=0; RAM contents need not be cleared.
REQ-032 Reset SHALL take priority over flush, writes and reads, including mid-FILL.

Structure
REQ-033 A shared package SHALL hold default parameter values, the FSM state enum and the clog2-derived widths.
REQ-034 Storage SHALL be one sub-module rk_bank_ram: simple dual-port, NUM_GEN*WORDS_PER_GEN words, 1-cycle registered read.

Verification
REQ-035 Write 95 beats (wr_last=0) -> COMMIT after beat 95, gen_count=1; read age 0 addr 94 -> word 94, rd_err=0, one cycle later.
REQ-036 Write 10-beat vector with wr_last on beat 10 -> len=10; read addr 10 -> rd_err=1, rd_data=0.
REQ-037 Commit 5 vectors (NUM_GEN=4) -> overflow pulses once at start of vector 5, gen_count=4; age 3 returns vector 2.
REQ-038 flush asserted mid-FILL after 3 commits -> gen_count=0, any age read rd_err=1; next write starts at word 0.
REQ-039 rd_req age 0 during COMMIT cycle of vector 2 -> returns vector 1 data.
REQ-040 reset low for one cycle mid-FILL -> all outputs at reset values, wr_ready=1 in following cycle.
